// File: rtl/kernel_window_formatter.sv
// Raster-to-3x3-column-group reorder stage feeding the convolution controller.
// Optional FMT_TLAST_CHECK_EN adds the sticky last_err tlast-placement check.
module kernel_window_formatter #(
  parameter int DATA_W    = 32,
  parameter int MAX_WIDTH = 1024,
  parameter int DIM_W     = 16
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              soft_rst,
  input  logic              enable,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  output logic              cfg_err,
`ifdef FMT_TLAST_CHECK_EN
  output logic              last_err,
`endif
  input  logic              s_axis_valid,
  input  logic [DATA_W-1:0] s_axis_data,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic              m_axis_valid,
  output logic [DATA_W-1:0] m_axis_data,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  output logic [3:0]        m_axis_keep
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W-1:0] MAXW  = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MIN_D = DIM_W'(3);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_EMIT0  = 3'd3;
  localparam logic [2:0] S_EMIT1  = 3'd4;
  localparam logic [2:0] S_EMIT2  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state;
  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-1:0]  h_q;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic              top;
  logic              last_pend;
  logic [DATA_W-1:0] nxt_q;
  logic [DATA_W-1:0] px_q;

  logic [DATA_W-1:0] lb0 [MAX_WIDTH];
  logic [DATA_W-1:0] lb1 [MAX_WIDTH];

  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] older_rd;
  logic [DATA_W-1:0] newer_rd;
  logic              wsel;
  logic              cfg_ok;
  logic              col_end;
  logic              row_end;
  logic              final_px;
  logic              acc;
  logic              hs;

  assign addr     = col[AW-1:0];
  assign older_rd = top ? lb1[addr] : lb0[addr];
  assign newer_rd = top ? lb0[addr] : lb1[addr];
  // FILL writes row r into buffer r; afterwards the older slot is recycled
  assign wsel     = (state == S_FILL) ? row[0] : top;
  assign cfg_ok   = (cfg_width >= MIN_D) && (cfg_width <= MAXW)
                 && (cfg_height >= MIN_D);
  assign col_end  = (col == w_q - ONE);
  assign row_end  = (row == h_q - ONE);
  assign final_px = col_end && row_end;

  always_comb begin
    s_axis_ready = 1'b0;
    case (state)
      S_FILL:   s_axis_ready = 1'b1;
      S_ACCEPT: s_axis_ready = 1'b1;
      S_EMIT2:  s_axis_ready = m_axis_ready && !last_pend;
      default:  s_axis_ready = 1'b0;
    endcase
  end

  assign acc         = s_axis_valid && s_axis_ready;
  assign hs          = m_axis_valid && m_axis_ready;
  assign m_axis_keep = m_axis_valid ? 4'hf : 4'h0;

  always_ff @(posedge axi_clk) begin
    if (acc) begin
      if (wsel) lb1[addr] <= s_axis_data;
      else      lb0[addr] <= s_axis_data;
    end
  end

`ifdef FMT_TLAST_CHECK_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      last_err <= 1'b0;
    end else if (soft_rst) begin
      last_err <= 1'b0;
    end else if (state == S_IDLE && enable && cfg_ok) begin
      last_err <= 1'b0;
    end else if (acc && (s_axis_last != final_px)) begin
      last_err <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = s_axis_last;
`endif

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state        <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      col          <= '0;
      row          <= '0;
      top          <= 1'b0;
      last_pend    <= 1'b0;
      nxt_q        <= '0;
      px_q         <= '0;
      cfg_err      <= 1'b0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
    end else if (soft_rst) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      top          <= 1'b0;
      last_pend    <= 1'b0;
      cfg_err      <= 1'b0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
    end else begin
      if (acc) begin
        if (col_end) begin
          col <= '0;
          row <= row + ONE;
          if (state != S_FILL) top <= ~top;
        end else begin
          col <= col + ONE;
        end
        if (state != S_FILL) begin
          m_axis_data  <= older_rd;
          nxt_q        <= newer_rd;
          px_q         <= s_axis_data;
          last_pend    <= final_px;
          m_axis_valid <= 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (enable && cfg_ok) begin
            w_q       <= cfg_width;
            h_q       <= cfg_height;
            col       <= '0;
            row       <= '0;
            top       <= 1'b0;
            last_pend <= 1'b0;
            cfg_err   <= 1'b0;
            state     <= S_FILL;
          end else if (enable) begin
            cfg_err <= 1'b1;
          end
        end
        S_FILL: begin
          if (acc && col_end && row == ONE) state <= S_ACCEPT;
        end
        S_ACCEPT: begin
          if (acc) state <= S_EMIT0;
        end
        S_EMIT0: begin
          if (hs) begin
            m_axis_data <= nxt_q;
            state       <= S_EMIT1;
          end
        end
        S_EMIT1: begin
          if (hs) begin
            m_axis_data <= px_q;
            m_axis_last <= last_pend;
            state       <= S_EMIT2;
          end
        end
        S_EMIT2: begin
          if (hs) begin
            m_axis_last <= 1'b0;
            if (last_pend) begin
              m_axis_valid <= 1'b0;
              state        <= S_DONE;
            end else if (acc) begin
              state <= S_EMIT0;
            end else begin
              m_axis_valid <= 1'b0;
              state        <= S_ACCEPT;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
